// File: rtl/iir_lookahead_mc_if.sv
// Sample, coefficient and result bus of the multichannel lookahead IIR core.
// SAT_STATUS_EN adds the sticky saturation status pair sat_clr/sat_flag.
interface iir_lookahead_mc_if #(
   parameter int WIDTH    = 42,
   parameter int IN_W     = 10,
   parameter int OUT_W    = 10,
   parameter int CHANNELS = 4,
   parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
   logic                    coef_we;
   logic [3:0]              coef_addr;
   logic signed [WIDTH-1:0] coef_data;
   logic                    coefficients_ready;
   logic signed [IN_W-1:0]  x_adc;
   logic [CH_W-1:0]         ch_in;
   logic                    sample_ready;
   logic                    in_ready;
   logic signed [OUT_W-1:0] y_n;
   logic [CH_W-1:0]         ch_out;
   logic                    valid_out;
`ifdef SAT_STATUS_EN
   logic                    sat_clr;
   logic [CHANNELS-1:0]     sat_flag;
`endif

   modport master (
      output coef_we, coef_addr, coef_data, coefficients_ready,
      output x_adc, ch_in, sample_ready,
`ifdef SAT_STATUS_EN
      output sat_clr,
      input  sat_flag,
`endif
      input  in_ready, y_n, ch_out, valid_out
   );

   modport slave (
      input  coef_we, coef_addr, coef_data, coefficients_ready,
      input  x_adc, ch_in, sample_ready,
`ifdef SAT_STATUS_EN
      input  sat_clr,
      output sat_flag,
`endif
      output in_ready, y_n, ch_out, valid_out
   );
endinterface

// File: rtl/iir_lookahead_mc.sv
// Multichannel lookahead IIR: y = sum bk*x[n-k] - a3*y[n-3] - a6*y[n-6].
// One shared sequential MAC; optional SAT_STATUS_EN sticky saturation flags.
module iir_lookahead_mc #(
   parameter int WHOLE_BITS = 10,
   parameter int FRAC_BITS  = 32,
   parameter int IN_W       = 10,
   parameter int OUT_W      = 10,
   parameter int CHANNELS   = 4
) (
   input logic         clk,
   input logic         reset,
   iir_lookahead_mc_if.slave bus
);
   localparam int WIDTH = WHOLE_BITS + FRAC_BITS;
   localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int SW    = (IN_W > OUT_W) ? IN_W : OUT_W;
   localparam int ACC_W = SW + WIDTH + 4;

   localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(CHANNELS);
   localparam logic signed [ACC_W-1:0] HALF_C = ACC_W'(1) << (FRAC_BITS - 1);
   localparam logic signed [ACC_W-1:0] Y_MAX  = ACC_W'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] Y_MIN  = ~Y_MAX;

   typedef enum logic [1:0] {IDLE, MAC, FINAL} state_t;

   state_t                  state_q, state_d;
   logic [3:0]              idx_q, idx_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [IN_W-1:0]  xcur_q, xcur_d;
   logic [CH_W-1:0]         ch_q, ch_d;
   logic signed [OUT_W-1:0] y_q, y_d;
   logic [CH_W-1:0]         cho_q, cho_d;
   logic                    vld_q, vld_d;

   logic signed [WIDTH-1:0] coef_q [9];
   logic signed [IN_W-1:0]  xh_q [CHANNELS][6];
   logic signed [OUT_W-1:0] yh_q [CHANNELS][6];

   logic signed [WIDTH-1:0] sel_c;
   logic signed [SW-1:0]    sel_x;
   logic signed [ACC_W-1:0] prod, rnd;
   logic signed [OUT_W-1:0] y_sat;
   logic                    sat_hit, accept;

   assign bus.in_ready  = (state_q == IDLE) && bus.coefficients_ready;
   assign bus.y_n       = y_q;
   assign bus.ch_out    = cho_q;
   assign bus.valid_out = vld_q;
   assign accept = bus.sample_ready && bus.in_ready && ({1'b0, bus.ch_in} < CH_LIM);

   // Select the coefficient/operand pair for the current MAC step.
   always_comb begin
      sel_c = '0;
      sel_x = '0;
      case (idx_q)
         4'd0: begin
            sel_c = coef_q[0];
            sel_x = SW'(xcur_q);
         end
         4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
            sel_c = coef_q[idx_q];
            sel_x = SW'(xh_q[ch_q][3'(idx_q - 4'd1)]);
         end
         4'd7: begin
            sel_c = coef_q[7];
            sel_x = SW'(yh_q[ch_q][2]);
         end
         4'd8: begin
            sel_c = coef_q[8];
            sel_x = SW'(yh_q[ch_q][5]);
         end
         default: ;
      endcase
      prod = ACC_W'(sel_c) * ACC_W'(sel_x);
   end

   // Round half toward +inf, then clamp to the output range.
   always_comb begin
      rnd     = (acc_q + HALF_C) >>> FRAC_BITS;
      sat_hit = 1'b1;
      if (rnd > Y_MAX)
         y_sat = OUT_W'(Y_MAX);
      else if (rnd < Y_MIN)
         y_sat = OUT_W'(Y_MIN);
      else begin
         y_sat   = OUT_W'(rnd);
         sat_hit = 1'b0;
      end
   end

   // FSM next state and datapath next values.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      xcur_d  = xcur_q;
      ch_d    = ch_q;
      y_d     = y_q;
      cho_d   = cho_q;
      vld_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = MAC;
               idx_d   = '0;
               acc_d   = '0;
               xcur_d  = bus.x_adc;
               ch_d    = bus.ch_in;
            end
         end
         MAC: begin
            acc_d = (idx_q >= 4'd7) ? acc_q - prod : acc_q + prod;
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd8)
               state_d = FINAL;
         end
         FINAL: begin
            y_d     = y_sat;
            cho_d   = ch_q;
            vld_d   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and datapath registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         acc_q   <= '0;
         xcur_q  <= '0;
         ch_q    <= '0;
         y_q     <= '0;
         cho_q   <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         xcur_q  <= xcur_d;
         ch_q    <= ch_d;
         y_q     <= y_d;
         cho_q   <= cho_d;
         vld_q   <= vld_d;
      end
   end

   // Coefficient bank; writable only while idle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 9; i++) coef_q[i] <= '0;
      end else if (state_q == IDLE && bus.coef_we && bus.coef_addr < 4'd9) begin
         coef_q[bus.coef_addr] <= bus.coef_data;
      end
   end

   // Per-channel history, shifted only on completion of that channel's sample.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int c = 0; c < CHANNELS; c++)
            for (int k = 0; k < 6; k++) begin
               xh_q[c][k] <= '0;
               yh_q[c][k] <= '0;
            end
      end else if (state_q == FINAL) begin
         xh_q[ch_q][0] <= xcur_q;
         yh_q[ch_q][0] <= y_sat;
         for (int k = 1; k < 6; k++) begin
            xh_q[ch_q][k] <= xh_q[ch_q][k-1];
            yh_q[ch_q][k] <= yh_q[ch_q][k-1];
         end
      end
   end

`ifdef SAT_STATUS_EN
   logic [CHANNELS-1:0] sat_q, sat_d;

   // Sticky flags: clear applies to all, a same-cycle set wins.
   always_comb begin
      sat_d = bus.sat_clr ? '0 : sat_q;
      if (state_q == FINAL && sat_hit)
         sat_d[ch_q] = 1'b1;
   end

   // Saturation flag register.
   always_ff @(posedge clk) begin
      if (!reset) sat_q <= '0;
      else        sat_q <= sat_d;
   end

   assign bus.sat_flag = sat_q;
`else
   logic unused_sat;
   assign unused_sat = sat_hit;
`endif
endmodule

// File: tb/tb_iir_lookahead_mc.sv
// Directed self-checking bench for iir_lookahead_mc.
// Covers pass-through, taps, feedback, channels, rounding/saturation, control.
module tb_iir_lookahead_mc;
   localparam logic signed [41:0] ONE  = 42'sd1 <<< 32;
   localparam logic signed [41:0] HALF = 42'sd1 <<< 31;
   localparam logic signed [41:0] FOUR = 42'sd1 <<< 34;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int checks = 0;
   int failures = 0;

   iir_lookahead_mc_if #(.WIDTH(42), .IN_W(10), .OUT_W(10), .CHANNELS(4)) bus ();

   iir_lookahead_mc dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.sample_ready = 1'b0;
      bus.coef_we = 1'b0;
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   task automatic wcoef(input logic [3:0] a, input logic signed [41:0] d);
      bus.coef_we = 1'b1;
      bus.coef_addr = a;
      bus.coef_data = d;
      tick();
      bus.coef_we = 1'b0;
   endtask

   task automatic send(input logic [1:0] ch, input logic signed [9:0] x,
                       output logic signed [9:0] gy, output logic [1:0] gc,
                       output int lat);
      int n;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      bus.sample_ready = 1'b1;
      bus.x_adc = x;
      bus.ch_in = ch;
      tick();
      bus.sample_ready = 1'b0;
      lat = -1;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (bus.valid_out === 1'b1) begin
            lat = i;
            break;
         end
      end
      gy = bus.y_n;
      gc = bus.ch_out;
   endtask

   task automatic test_reset();
      bus.coefficients_ready = 1'b0;
      do_reset();
      checks++;
      if (bus.y_n !== 10'sd0 || bus.ch_out !== 2'd0 || bus.valid_out !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: y=%0d ch=%0d v=%b required 0 0 0",
                  bus.y_n, bus.ch_out, bus.valid_out);
      end
      checks++;
      if (bus.in_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_in_ready_low: got %b required 0", bus.in_ready);
      end
      bus.coefficients_ready = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready_high: got %b required 1", bus.in_ready);
      end
   endtask

   task automatic test_pass();
      logic signed [9:0] y;
      logic [1:0] c;
      int lat;
      do_reset();
      wcoef(4'd0, ONE);
      send(2'd0, 10'sd100, y, c, lat);
      checks++;
      if (lat !== 10 || y !== 10'sd100 || c !== 2'd0) begin
         failures++;
         $display("FAIL pass: lat=%0d y=%0d ch=%0d required 10 100 0", lat, y, c);
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL pass_in_ready: got %b required 1", bus.in_ready);
      end
      tick();
      checks++;
      if (bus.valid_out !== 1'b0 || bus.y_n !== 10'sd100) begin
         failures++;
         $display("FAIL pass_strobe: v=%b y=%0d required 0 100", bus.valid_out, bus.y_n);
      end
   endtask

   task automatic test_delay();
      logic signed [9:0] xs [4] = '{10'sd100, 10'sd0, 10'sd0, 10'sd0};
      logic signed [9:0] es [4] = '{10'sd0, 10'sd0, 10'sd0, 10'sd100};
      logic signed [9:0] y;
      logic [1:0] c;
      int lat;
      do_reset();
      wcoef(4'd3, ONE);
      for (int i = 0; i < 4; i++) begin
         send(2'd1, xs[i], y, c, lat);
         checks++;
         if (lat !== 10 || y !== es[i] || c !== 2'd1) begin
            failures++;
            $display("FAIL delay[%0d]: lat=%0d y=%0d ch=%0d required 10 %0d 1",
                     i, lat, y, c, es[i]);
         end
      end
   endtask

   task automatic test_feedback();
      logic signed [9:0] es [7] = '{10'sd200, 10'sd0, 10'sd0, 10'sd100,
                                    10'sd0, 10'sd0, 10'sd50};
      logic signed [9:0] y;
      logic [1:0] c;
      int lat;
      do_reset();
      wcoef(4'd0, ONE);
      wcoef(4'd7, -HALF);
      for (int i = 0; i < 7; i++) begin
         send(2'd0, (i == 0) ? 10'sd200 : 10'sd0, y, c, lat);
         checks++;
         if (y !== es[i] || c !== 2'd0) begin
            failures++;
            $display("FAIL feedback[%0d]: y=%0d ch=%0d required %0d 0", i, y, c, es[i]);
         end
      end
   endtask

   task automatic test_isolation();
      logic signed [9:0] e0 [7] = '{10'sd200, 10'sd0, 10'sd0, 10'sd100,
                                    10'sd0, 10'sd0, 10'sd50};
      logic signed [9:0] e2 [7] = '{-10'sd40, 10'sd0, 10'sd0, -10'sd20,
                                    10'sd0, 10'sd0, -10'sd10};
      logic signed [9:0] y;
      logic [1:0] c;
      int lat;
      do_reset();
      wcoef(4'd0, ONE);
      wcoef(4'd7, -HALF);
      for (int i = 0; i < 7; i++) begin
         send(2'd0, (i == 0) ? 10'sd200 : 10'sd0, y, c, lat);
         checks++;
         if (y !== e0[i] || c !== 2'd0) begin
            failures++;
            $display("FAIL iso_ch0[%0d]: y=%0d ch=%0d required %0d 0", i, y, c, e0[i]);
         end
         send(2'd2, (i == 0) ? -10'sd40 : 10'sd0, y, c, lat);
         checks++;
         if (y !== e2[i] || c !== 2'd2) begin
            failures++;
            $display("FAIL iso_ch2[%0d]: y=%0d ch=%0d required %0d 2", i, y, c, e2[i]);
         end
      end
   endtask

   task automatic test_round_sat();
      logic signed [9:0] xs [4] = '{10'sd3, -10'sd3, 10'sd200, -10'sd200};
      logic signed [9:0] es [4] = '{10'sd2, -10'sd1, 10'sd511, -10'sd512};
      logic signed [9:0] y;
      logic [1:0] c;
      int lat;
      do_reset();
`ifdef SAT_STATUS_EN
      bus.sat_clr = 1'b0;
`endif
      wcoef(4'd0, HALF);
      for (int i = 0; i < 4; i++) begin
         if (i == 2) wcoef(4'd0, FOUR);
         send(2'd0, xs[i], y, c, lat);
         checks++;
         if (y !== es[i]) begin
            failures++;
            $display("FAIL round_sat[%0d]: y=%0d required %0d", i, y, es[i]);
         end
`ifdef SAT_STATUS_EN
         checks++;
         if (bus.sat_flag[0] !== (i >= 2)) begin
            failures++;
            $display("FAIL sat_flag[%0d]: got %b required %b", i, bus.sat_flag[0], i >= 2);
         end
`endif
      end
`ifdef SAT_STATUS_EN
      bus.sat_clr = 1'b1;
      tick();
      bus.sat_clr = 1'b0;
      checks++;
      if (bus.sat_flag !== 4'b0000) begin
         failures++;
         $display("FAIL sat_clr: got %b required 0000", bus.sat_flag);
      end
`endif
   endtask

   task automatic test_control();
      logic signed [9:0] y;
      logic [1:0] c;
      int lat;
      int seen;
      do_reset();
      wcoef(4'd0, ONE);
      bus.coefficients_ready = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
         failures++;
         $display("FAIL ctl_in_ready: got %b required 0", bus.in_ready);
      end
      bus.sample_ready = 1'b1;
      bus.x_adc = 10'sd77;
      bus.ch_in = 2'd0;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         if (i == 3) bus.sample_ready = 1'b0;
         tick();
         if (bus.valid_out === 1'b1) seen++;
      end
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL ctl_not_ready: valid count %0d required 0", seen);
      end
      bus.coefficients_ready = 1'b1;
      bus.sample_ready = 1'b1;
      bus.x_adc = 10'sd50;
      tick();
      bus.sample_ready = 1'b0;
      tick();
      tick();
      wcoef(4'd0, FOUR);
      lat = -1;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (bus.valid_out === 1'b1) begin
            lat = i;
            break;
         end
      end
      checks++;
      if (lat < 0 || bus.y_n !== 10'sd50) begin
         failures++;
         $display("FAIL ctl_we_in_mac: lat=%0d y=%0d required 50", lat, bus.y_n);
      end
      send(2'd0, 10'sd50, y, c, lat);
      checks++;
      if (y !== 10'sd50) begin
         failures++;
         $display("FAIL ctl_we_ignored: y=%0d required 50", y);
      end
      bus.coef_we = 1'b1;
      bus.coef_addr = 4'd0;
      bus.coef_data = ONE + ONE;
      send(2'd3, 10'sd10, y, c, lat);
      bus.coef_we = 1'b0;
      checks++;
      if (y !== 10'sd20 || c !== 2'd3) begin
         failures++;
         $display("FAIL ctl_we_with_accept: y=%0d ch=%0d required 20 3", y, c);
      end
   endtask

   task automatic test_reset_abort();
      logic signed [9:0] y;
      logic [1:0] c;
      int lat;
      int seen;
      do_reset();
      wcoef(4'd0, ONE);
      send(2'd0, 10'sd30, y, c, lat);
      wcoef(4'd1, ONE);
      bus.sample_ready = 1'b1;
      bus.x_adc = 10'sd100;
      bus.ch_in = 2'd0;
      tick();
      bus.sample_ready = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      checks++;
      if (bus.y_n !== 10'sd0 || bus.valid_out !== 1'b0) begin
         failures++;
         $display("FAIL abort_reset_out: y=%0d v=%b required 0 0", bus.y_n, bus.valid_out);
      end
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (bus.valid_out === 1'b1) seen++;
      end
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL abort_no_valid: valid count %0d required 0", seen);
      end
      wcoef(4'd0, ONE);
      wcoef(4'd1, ONE);
      send(2'd0, 10'sd100, y, c, lat);
      checks++;
      if (lat !== 10 || y !== 10'sd100) begin
         failures++;
         $display("FAIL abort_clean0: lat=%0d y=%0d required 10 100", lat, y);
      end
      send(2'd0, 10'sd0, y, c, lat);
      checks++;
      if (y !== 10'sd100) begin
         failures++;
         $display("FAIL abort_clean1: y=%0d required 100", y);
      end
   endtask

   initial begin
      bus.coef_we = 1'b0;
      bus.coef_addr = 4'd0;
      bus.coef_data = '0;
      bus.coefficients_ready = 1'b0;
      bus.x_adc = '0;
      bus.ch_in = '0;
      bus.sample_ready = 1'b0;
`ifdef SAT_STATUS_EN
      bus.sat_clr = 1'b0;
`endif
      tick();
      test_reset();
      test_pass();
      test_delay();
      test_feedback();
      test_isolation();
      test_round_sat();
      test_control();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
